// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 operation codes, the control state encoding and the default width.
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes on
// start, one bit is processed per cycle (shift-add or restoring divide), and
// the sign is restored in a single fix-up cycle before the write-back pulse.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic            we,
   output logic [4:0]      rd_out,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_reg, state_next;
   logic [CW-1:0]     cnt_reg;
   logic [2:0]        op_reg;
   logic [4:0]        rd_reg;
   logic              neg_reg;
   logic [XLEN-1:0]   a_reg;
   logic [XLEN-1:0]   b_reg;
   logic [XLEN-1:0]   result_reg;
   // Multiply: full product. Divide: low half is dividend shifting out / quotient shifting in.
   logic [2*XLEN-1:0] work_reg;
   logic [XLEN:0]     rem_reg;

   // Decode signals for the incoming request
   logic              rs1_neg, rs2_neg, start_neg;
   logic [XLEN-1:0]   rs1_mag, rs2_mag;
   logic              fast_path;
   logic [XLEN-1:0]   fast_result;
   logic              accept;

   // Iteration and fix-up datapath
   logic [XLEN:0]     mul_sum;
   logic [XLEN+1:0]   div_diff;
   logic              q_bit;
   logic [2*XLEN-1:0] work_step;
   logic [XLEN:0]     rem_step;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

   // Request decode: operand signedness, magnitudes, result sign and fast-path detection
   always_comb begin
      logic rs1_signed, rs2_signed, div_zero, div_ovf;
      rs1_signed  = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV)  || (funct3 == F3_REM);
      rs2_signed  = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
      rs1_neg     = rs1_signed && rs1_data[XLEN-1];
      rs2_neg     = rs2_signed && rs2_data[XLEN-1];
      rs1_mag     = rs1_neg ? -rs1_data : rs1_data;
      rs2_mag     = rs2_neg ? -rs2_data : rs2_data;
      // Remainder takes the dividend's sign; everything else the XOR of both signs
      start_neg   = (funct3 == F3_REM) ? rs1_neg : (rs1_neg ^ rs2_neg);
      div_zero    = funct3[2] && (rs2_data == '0);
      div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (rs1_data == MIN_NEG) && (rs2_data == '1);
      fast_path   = div_zero || div_ovf;
      fast_result = '0;
      if (div_zero)
         fast_result = funct3[1] ? rs1_data : '1;
      else if (div_ovf)
         fast_result = funct3[1] ? '0 : MIN_NEG;
      accept      = (state_reg == ST_IDLE) && start && !kill;
   end

   // One iteration step for both operations plus the sign fix-up and result select
   always_comb begin
      mul_sum   = {1'b0, work_reg[2*XLEN-1:XLEN]} + (work_reg[0] ? {1'b0, a_reg} : '0);
      div_diff  = {rem_reg, work_reg[XLEN-1]} - {2'b00, b_reg};
      q_bit     = ~div_diff[XLEN+1];
      work_step = {mul_sum, work_reg[XLEN-1:1]};
      rem_step  = rem_reg;
      if (op_reg[2]) begin
         work_step = {work_reg[2*XLEN-1:XLEN], work_reg[XLEN-2:0], q_bit};
         rem_step  = q_bit ? div_diff[XLEN:0] : {rem_reg[XLEN-1:0], work_reg[XLEN-1]};
      end
      prod_fix = neg_reg ? -work_reg : work_reg;
      quot_fix = neg_reg ? -work_reg[XLEN-1:0] : work_reg[XLEN-1:0];
      rem_fix  = neg_reg ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];
      case (op_reg)
         F3_MUL:                       fix_result = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              fix_result = quot_fix;
         default:                      fix_result = rem_fix;
      endcase
   end

   // Control state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state and handshake outputs; kill overrides every transition
   always_comb begin
      state_next = state_reg;
      busy       = (state_reg != ST_IDLE);
      done       = 1'b0;
      case (state_reg)
         ST_IDLE: if (start) state_next = fast_path ? ST_DONE : ST_CALC;
         ST_CALC: if (cnt_reg == CNT_LAST) state_next = ST_FIX;
         ST_FIX:  state_next = ST_DONE;
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (kill) begin
         state_next = ST_IDLE;
         done       = 1'b0;
      end
   end

   // Datapath registers: latch on accept, iterate in CALC, commit the result in FIX
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg    <= '0;
         op_reg     <= '0;
         rd_reg     <= '0;
         neg_reg    <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         work_reg   <= '0;
         rem_reg    <= '0;
         result_reg <= '0;
      end else if (accept) begin
         cnt_reg  <= '0;
         op_reg   <= funct3;
         rd_reg   <= rd;
         neg_reg  <= start_neg;
         a_reg    <= rs1_mag;
         b_reg    <= rs2_mag;
         work_reg <= {{XLEN{1'b0}}, (funct3[2] ? rs1_mag : rs2_mag)};
         rem_reg  <= '0;
         if (fast_path)
            result_reg <= fast_result;
      end else if (!kill && state_reg == ST_CALC) begin
         cnt_reg  <= cnt_reg + 1'b1;
         work_reg <= work_step;
         rem_reg  <= rem_step;
      end else if (!kill && state_reg == ST_FIX) begin
         result_reg <= fix_result;
      end
   end

   assign we     = done;
   assign rd_out = rd_reg;
   assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases, handshake
// (start while busy, kill, asynchronous reset) and randomized operations
// compared against an arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  rd;
   logic        kill;
   logic        busy, done, we;
   logic [4:0]  rd_out;
   logic [31:0] result;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_result;

   muldiv_unit #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .funct3   (funct3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd       (rd),
      .kill     (kill),
      .busy     (busy),
      .done     (done),
      .we       (we),
      .rd_out   (rd_out),
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3 >= 3'd4 && b == 32'd0) return 1'b1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
      return 1'b0;
   endfunction

   // Reference: plain 64-bit arithmetic following the RV32M definitions
   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub, p;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = ua * ub;          return p[31:0];  end
         3'd1: begin p = 64'(sa * sb);     return p[63:32]; end
         3'd2: begin p = 64'(sa) * ub;     return p[63:32]; end
         3'd3: begin p = ua * ub;          return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return a;
            p = 64'(sa / sb); return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf)    return 32'h0;
            p = 64'(sa % sb); return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issue one operation and check latency, result, write-back and pulse width.
   // With poke_busy set, a conflicting start is pulsed five cycles into the op.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic poke_busy);
      logic [31:0] exp;
      int          exp_lat;
      int          lat;
      exp     = ref_result(f3, a, b);
      exp_lat = is_fast(f3, a, b) ? 1 : 34;
      @(negedge clk);
      start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd = r;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      check("busy_after_start", busy, 1);
      while (!done && lat < 80) begin
         @(negedge clk);
         lat++;
         if (poke_busy && lat == 5) begin
            start = 1'b1; funct3 = 3'd0; rs1_data = 32'd1; rs2_data = 32'd1; rd = ~r;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check("latency", 64'(lat), 64'(exp_lat));
      check("result", result, exp);
      check("we", we, 1);
      check("rd_out", rd_out, r);
      $display("op f3=%0d a=%h b=%h rd=%0d result=%h expected=%h lat=%0d",
               f3, a, b, r, result, exp, lat);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_back_idle", busy, 0);
      check("result_held", result, exp);
      last_result = exp;
   endtask

   logic [2:0]  d_f3 [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd4, 3'd7, 3'd4, 3'd6, 3'd1, 3'd5};
   logic [31:0] d_a  [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                             32'h1234_5678, 32'h0000_0003};
   logic [31:0] d_b  [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd2, 32'd2, 32'd2, 32'd2,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFEDC_BA98, 32'h0000_0007};
   logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                 32'h7FFF_FFFF, 32'hFFFF_FFFE};

   initial begin
      int          seen;
      logic [31:0] ra, rb;
      rst = 1'b1; start = 1'b0; kill = 1'b0;
      funct3 = '0; rs1_data = '0; rs2_data = '0; rd = '0;
      last_result = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_result", result, 0);
      check("reset_rd_out", rd_out, 0);
      rst = 1'b0;

      // Directed corner cases, including the divide fast paths
      for (int i = 0; i < 14; i++)
         run_op(d_f3[i], d_a[i], d_b[i], 5'(i + 3), 1'b0);

      // start while busy must be ignored
      run_op(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd17, 1'b1);

      // kill ten cycles into CALC: no done, result unchanged
      @(negedge clk);
      start = 1'b1; funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd = 5'd21;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill_busy_low", busy, 0);
      check("kill_done_low", done, 0);
      check("kill_result_kept", result, last_result);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("kill_no_done", 64'(seen), 0);
      $display("op kill mid-calc busy=%0d result=%h", busy, result);

      // kill together with start in IDLE: nothing accepted
      start = 1'b1; kill = 1'b1; funct3 = 3'd4; rs1_data = 32'd5; rs2_data = 32'd0;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      check("kill_start_idle", busy, 0);
      $display("op kill+start in idle busy=%0d", busy);

      // asynchronous reset mid-CALC, between clock edges
      @(negedge clk);
      start = 1'b1; funct3 = 3'd3; rs1_data = 32'hFFFF_0000; rs2_data = 32'h1234; rd = 5'd30;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_we", we, 0);
      check("arst_rd_out", rd_out, 0);
      check("arst_result", result, 0);
      $display("op async reset mid-calc busy=%0d result=%h", busy, result);
      @(negedge clk);
      rst = 1'b0;
      last_result = '0;
      run_op(3'd0, 32'd3, 32'd4, 5'd9, 1'b0);

      // Randomized operations with biased special operands
      for (int i = 0; i < 40; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         run_op(3'($urandom_range(0, 7)), ra, rb, 5'($urandom_range(0, 31)), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting in the execute stage beside the ALU. It consumes `rs1_data`/`rs2_data` from the register file and writes its result back through the register file write port (`we`/`rd`/`rd_data`). One operation runs at a time under a start/busy/done handshake, with a fixed 34-cycle latency and single-cycle fast paths for divide special cases.

## Interface
- `XLEN`, 32, operand/result width; iteration count equals `XLEN`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_data`  in  XLEN  multiplicand / dividend.
- `rs2_data`  in  XLEN  multiplier / divisor.
- `rd`  in  5  destination register, latched with the operands.
- `kill`  in  1  pipeline flush; aborts the operation in flight.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `we`  out  1  equals `done`; drives the register file write enable.
- `rd_out`  out  5  latched `rd`.
- `result`  out  XLEN  result; holds its value until the next `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE + `start`: latch `funct3`, `rd`, and operand magnitudes. Signedness per op: MULH/DIV/REM signed×signed; MULHSU signed×unsigned; MULHU/DIVU/REMU unsigned; MUL sign-irrelevant, treated as unsigned. Latch the result sign.
  - Multiply result sign: XOR of operand signs.
  - DIV sign: XOR of operand signs. REM sign: dividend sign.
  - Go to CALC and clear the iteration counter.
- CALC, multiply: shift-add on the magnitudes into a 2·XLEN product register, one bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle; the remainder register is XLEN+1 bits.
- Leave CALC after the counter reaches XLEN−1, i.e. exactly XLEN cycles.
- FIX: negate the product (2·XLEN two's complement), quotient, or remainder if the latched sign is set. Select the low half (MUL), the high half (MULH*), the quotient, or the remainder. Register into `result`. Go to DONE.
- DONE: `done = we = 1`. Go to IDLE.
- Fast path, taken from IDLE with `start`, goes directly to DONE:
  - Divisor = 0: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- `start` outside IDLE is ignored; no queuing.
- `kill` in CALC/FIX/DONE: go to IDLE on the next edge. `done`/`we` are forced low that cycle. `result` keeps its old value.
- `kill` together with `start` in IDLE: `kill` wins and nothing is accepted.
- `kill` has priority over all transitions. Reset has priority over everything.

## Timing
- `start` sampled at edge E0 → CALC for XLEN cycles → FIX for 1 cycle → `done` high in the cycle after edge E0+XLEN+1. For XLEN=32 that is 34 cycles after the start cycle.
- Fast path: `done` high in the cycle immediately after the start cycle.
- `busy` rises in the cycle after `start` is accepted and falls when returning to IDLE. A new `start` is accepted no earlier than the cycle after `done`.
- Reset (asynchronous, takes effect immediately): state IDLE, `busy` 0, `done` 0, `we` 0, `rd_out` 0, `result` 0, all datapath registers 0. Reset mid-CALC discards the operation.

## Structure
- Shared package `muldiv_pkg`: the funct3 op constants, the state enum (IDLE/CALC/FIX/DONE), and the `XLEN` default constant.
- Single module with no sub-modules. Multiply and divide share the iteration counter and the 2·XLEN working register; sign fix-up is inline in FIX.

## Test plan
- MUL, 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB, `rd_out` = latched `rd`, `done`/`we` high for exactly one cycle, 34 cycles after `start`.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divides: DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU 0xFFFFFFF9/2 → 1.
- Fast paths, each with `done` 1 cycle after `start`:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Handshake:
  - `start` pulsed while `busy` → ignored, the first op completes unaltered.
  - `kill` 10 cycles into CALC → `busy` low next cycle, no `done`, `result` unchanged.
- `rst` asserted mid-CALC, between clock edges → all outputs 0 immediately. After release, a fresh MUL 3×4 → 12.
